// File: rtl/rl_desc_app_qm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rl_desc_app_qm                                                   |
// | Desc    : per-app circular descriptor queues feeding a PIFO scheduler;     |
// |           optional full-queue drop counter under RL_QM_DROP_CNT_EN.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+

`ifndef APP_ID_WIDTH
`define APP_ID_WIDTH 4
`endif
`ifndef RL_DESC_WIDTH
`define RL_DESC_WIDTH 16
`endif
`ifndef RL_DESC_APP_ID_SIZE
`define RL_DESC_APP_ID_SIZE 4
`endif

module rl_desc_app_qm #(
  parameter int NUM_APPS    = 2**`APP_ID_WIDTH,
  parameter int QUEUE_DEPTH = 16,
  parameter int DESC_WIDTH  = `RL_DESC_WIDTH,
  parameter int APP_W       = `RL_DESC_APP_ID_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DESC_WIDTH-1:0]     s_packet_desc,
  input  logic [APP_W-1:0]          s_packet_desc_app_id,
  input  logic                      s_packet_desc_valid,
  output logic                      s_packet_desc_ready,
  input  logic [NUM_APPS*APP_W-1:0] s_app_prio,
  output logic                      m_pifo_valid,
  output logic [APP_W-1:0]          m_pifo_prio,
  output logic [APP_W-1:0]          m_pifo_data,
  input  logic                      m_pifo_ready,
  output logic                      m_pifo_empty,
  output logic [APP_W-1:0]          m_pifo_empty_data,
  input  logic                      qm_packet_desc_req,
  input  logic [APP_W-1:0]          qm_packet_desc_app_id,
  output logic [DESC_WIDTH-1:0]     qm_packet_desc,
  output logic                      qm_packet_desc_valid,
`ifdef RL_QM_DROP_CNT_EN
  output logic [31:0]               qm_drop_cnt,
`endif
  output logic                      qm_req_err
);

  localparam int QW     = $clog2(QUEUE_DEPTH);
  localparam int PTR_W  = QW + 1;
  localparam int ADDR_W = APP_W + QW;

  logic [PTR_W-1:0]      r_head [NUM_APPS];
  logic [PTR_W-1:0]      r_tail [NUM_APPS];
  logic [NUM_APPS-1:0]   r_sched;
  logic [NUM_APPS-1:0]   w_sched_nxt;
  logic [NUM_APPS-1:0]   w_full;
  logic [NUM_APPS-1:0]   w_empty;
  logic [NUM_APPS-1:0]   w_last;
  logic [NUM_APPS-1:0]   w_pending;
  logic [DESC_WIDTH-1:0] r_mem [NUM_APPS*QUEUE_DEPTH];

  logic                  r_in_ready;
  logic                  r_pvalid;
  logic [APP_W-1:0]      r_pprio;
  logic [APP_W-1:0]      r_pdata;
  logic                  r_rd_valid;
  logic [DESC_WIDTH-1:0] r_rd_data;
  logic                  r_req_err;
  logic                  r_empty;
  logic [APP_W-1:0]      r_empty_data;

  logic                  w_enq_fire;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_deq_err;
  logic                  w_drain;
  logic                  w_push_acc;
  logic [APP_W-1:0]      w_sel;
  logic [ADDR_W-1:0]     w_wr_addr;
  logic [ADDR_W-1:0]     w_rd_addr;

  // Occupancy from the wrap-bit pointers: equal = empty, MSB-only difference = full.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_APPS; gi++) begin : g_app
      logic [PTR_W-1:0] w_occ;
      assign w_occ         = r_tail[gi] - r_head[gi];
      assign w_empty[gi]   = (w_occ == '0);
      assign w_full[gi]    = (w_occ == PTR_W'(QUEUE_DEPTH));
      assign w_last[gi]    = (w_occ == PTR_W'(1));
      assign w_pending[gi] = ~w_empty[gi] & ~r_sched[gi];
    end
  endgenerate

  assign w_enq_fire = s_packet_desc_valid & r_in_ready;
  assign w_enq      = w_enq_fire & ~w_full[s_packet_desc_app_id];
  assign w_deq      = qm_packet_desc_req & ~w_empty[qm_packet_desc_app_id];
  assign w_deq_err  = qm_packet_desc_req & w_empty[qm_packet_desc_app_id];
  assign w_drain    = w_deq & w_last[qm_packet_desc_app_id] &
                      ~(w_enq & (s_packet_desc_app_id == qm_packet_desc_app_id));
  assign w_push_acc = r_pvalid & m_pifo_ready;
  assign w_wr_addr  = {s_packet_desc_app_id, r_tail[s_packet_desc_app_id][QW-1:0]};
  assign w_rd_addr  = {qm_packet_desc_app_id, r_head[qm_packet_desc_app_id][QW-1:0]};

  always_comb begin
    w_sel = '0;
    for (int i = NUM_APPS - 1; i >= 0; i--) begin
      if (w_pending[i]) w_sel = APP_W'(i);
    end
  end

  // A dequeue clear overrides a same-cycle push acceptance for the same app.
  always_comb begin
    w_sched_nxt = r_sched;
    if (w_push_acc) w_sched_nxt[r_pdata] = 1'b1;
    if (w_deq)      w_sched_nxt[qm_packet_desc_app_id] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_APPS; i++) begin
        r_head[i] <= '0;
        r_tail[i] <= '0;
      end
      r_sched <= '0;
    end else begin
      if (w_enq) r_tail[s_packet_desc_app_id]  <= r_tail[s_packet_desc_app_id] + PTR_W'(1);
      if (w_deq) r_head[qm_packet_desc_app_id] <= r_head[qm_packet_desc_app_id] + PTR_W'(1);
      r_sched <= w_sched_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[w_wr_addr] <= s_packet_desc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_req_err    <= 1'b0;
      r_empty      <= 1'b0;
      r_empty_data <= '0;
    end else begin
      r_in_ready   <= 1'b1;
      r_rd_valid   <= w_deq;
      r_req_err    <= w_deq_err;
      r_empty      <= w_drain;
      r_empty_data <= w_drain ? qm_packet_desc_app_id : '0;
      if (w_deq) r_rd_data <= r_mem[w_rd_addr];
    end
  end

  // Selection only happens while idle, so a held push can never be re-picked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pvalid <= 1'b0;
      r_pprio  <= '0;
      r_pdata  <= '0;
    end else if (w_push_acc) begin
      r_pvalid <= 1'b0;
    end else if (!r_pvalid && (|w_pending)) begin
      r_pvalid <= 1'b1;
      r_pdata  <= w_sel;
      r_pprio  <= s_app_prio[w_sel*APP_W +: APP_W];
    end
  end

`ifdef RL_QM_DROP_CNT_EN
  logic        w_drop;
  logic [31:0] r_drop_cnt;
  assign w_drop = w_enq_fire & w_full[s_packet_desc_app_id];
  always_ff @(posedge clk) begin
    if (rst)                            r_drop_cnt <= '0;
    else if (w_drop && ~&r_drop_cnt)    r_drop_cnt <= r_drop_cnt + 32'd1;
  end
  assign qm_drop_cnt = r_drop_cnt;
`endif

  assign s_packet_desc_ready  = r_in_ready;
  assign m_pifo_valid         = r_pvalid;
  assign m_pifo_prio          = r_pprio;
  assign m_pifo_data          = r_pdata;
  assign m_pifo_empty         = r_empty;
  assign m_pifo_empty_data    = r_empty_data;
  assign qm_packet_desc       = r_rd_data;
  assign qm_packet_desc_valid = r_rd_valid;
  assign qm_req_err           = r_req_err;

endmodule

`default_nettype wire

// File: tb/tb_rl_desc_app_qm.sv
`default_nettype none
// Testbench for rl_desc_app_qm: cycle-by-cycle vector table plus hand-written
// overflow and mid-operation reset sequences.

module tb_rl_desc_app_qm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_desc;
  logic [3:0]  s_id;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] prio;
  logic        p_valid;
  logic [3:0]  p_prio;
  logic [3:0]  p_data;
  logic        p_ready;
  logic        p_empty;
  logic [3:0]  p_empty_data;
  logic        q_req;
  logic [3:0]  q_id;
  logic [15:0] q_desc;
  logic        q_valid;
  logic        q_err;
`ifdef RL_QM_DROP_CNT_EN
  logic [31:0] drop_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rl_desc_app_qm #(.NUM_APPS(16), .QUEUE_DEPTH(16), .DESC_WIDTH(16), .APP_W(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_packet_desc        (s_desc),
    .s_packet_desc_app_id (s_id),
    .s_packet_desc_valid  (s_valid),
    .s_packet_desc_ready  (s_ready),
    .s_app_prio           (prio),
    .m_pifo_valid         (p_valid),
    .m_pifo_prio          (p_prio),
    .m_pifo_data          (p_data),
    .m_pifo_ready         (p_ready),
    .m_pifo_empty         (p_empty),
    .m_pifo_empty_data    (p_empty_data),
    .qm_packet_desc_req   (q_req),
    .qm_packet_desc_app_id(q_id),
    .qm_packet_desc       (q_desc),
    .qm_packet_desc_valid (q_valid),
`ifdef RL_QM_DROP_CNT_EN
    .qm_drop_cnt          (drop_cnt),
`endif
    .qm_req_err           (q_err)
  );

  typedef struct {
    logic        ev;
    logic [3:0]  eid;
    logic [15:0] d;
    logic        rq;
    logic [3:0]  rid;
    logic        rdy;
    logic        xpv;
    logic [3:0]  xpd;
    logic        xdv;
    logic [15:0] xd;
    logic        xemp;
    logic [3:0]  xed;
    logic        xerr;
  } vec_t;

  vec_t vq[$];

  // Bench priority map: app a is programmed with priority a-1 (mod 16).
  function automatic logic [3:0] prio_of(input logic [3:0] a);
    return a - 4'd1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input int ev, input int eid, input int d, input int rq, input int rid,
                     input int rdy, input int xpv, input int xpd, input int xdv, input int xd,
                     input int xemp, input int xed, input int xerr);
    vec_t v;
    v.ev = ev[0]; v.eid = eid[3:0]; v.d = d[15:0]; v.rq = rq[0]; v.rid = rid[3:0];
    v.rdy = rdy[0]; v.xpv = xpv[0]; v.xpd = xpd[3:0]; v.xdv = xdv[0]; v.xd = xd[15:0];
    v.xemp = xemp[0]; v.xed = xed[3:0]; v.xerr = xerr[0];
    vq.push_back(v);
  endtask

  task automatic step(input logic ev, input logic [3:0] eid, input logic [15:0] d,
                      input logic rq, input logic [3:0] rid, input logic rdy);
    s_valid = ev; s_id = eid; s_desc = d;
    q_req = rq; q_id = rid; p_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, rdy);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prio[i*4 +: 4] = prio_of(4'(i));
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("rst_ready", s_ready, 0);
    chk("rst_pvalid", p_valid, 0);
    chk("rst_pdata", p_data, 0);
    chk("rst_pprio", p_prio, 0);
    chk("rst_qvalid", q_valid, 0);
    chk("rst_qdesc", q_desc, 0);
    chk("rst_err", q_err, 0);
    chk("rst_empty", p_empty, 0);
    rst = 1'b0;
    idle(1'b0);
    chk("ready_after_rst", s_ready, 1);

    // ev eid  d      rq rid rdy | xpv xpd xdv xd     xemp xed xerr
    add(1, 3, 'hA5,  0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    1, 3,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    1, 3,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     1, 3,  0,    0, 0,  1, 'hA5,  1, 3,  0);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(1, 5, 1,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(1, 5, 2,     0, 0,  0,    1, 5,  0, 0,     0, 0,  0);
    add(1, 5, 3,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     1, 5,  0,    0, 0,  1, 1,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    1, 5,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     1, 5,  0,    0, 0,  1, 2,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    1, 5,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     1, 5,  0,    0, 0,  1, 3,     1, 5,  0);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     1, 7,  0,    0, 0,  0, 0,     0, 0,  1);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(1, 12, 'hC0, 0, 0,  0,    0, 0,  0, 0,     0, 0,  0);
    add(1, 9, 'h90,  0, 0,  0,    1, 12, 0, 0,     0, 0,  0);
    add(1, 2, 'h20,  0, 0,  0,    1, 12, 0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    1, 2,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    1, 9,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     0, 0,  1,    0, 0,  0, 0,     0, 0,  0);
    add(0, 0, 0,     1, 12, 0,    0, 0,  1, 'hC0,  1, 12, 0);
    add(0, 0, 0,     1, 2,  0,    0, 0,  1, 'h20,  1, 2,  0);
    add(0, 0, 0,     1, 9,  0,    0, 0,  1, 'h90,  1, 9,  0);
    add(0, 0, 0,     0, 0,  0,    0, 0,  0, 0,     0, 0,  0);

    foreach (vq[k]) begin
      step(vq[k].ev, vq[k].eid, vq[k].d, vq[k].rq, vq[k].rid, vq[k].rdy);
      chk($sformatf("v%0d_pvalid", k), p_valid, vq[k].xpv);
      if (vq[k].xpv) begin
        chk($sformatf("v%0d_pdata", k), p_data, vq[k].xpd);
        chk($sformatf("v%0d_pprio", k), p_prio, prio_of(vq[k].xpd));
      end
      chk($sformatf("v%0d_qvalid", k), q_valid, vq[k].xdv);
      if (vq[k].xdv) chk($sformatf("v%0d_qdesc", k), q_desc, vq[k].xd);
      chk($sformatf("v%0d_empty", k), p_empty, vq[k].xemp);
      if (vq[k].xemp) chk($sformatf("v%0d_empty_data", k), p_empty_data, vq[k].xed);
      chk($sformatf("v%0d_err", k), q_err, vq[k].xerr);
    end

    // Overflow app 0: 18 writes into a 16-deep queue, last two dropped.
    for (int k = 1; k <= 18; k++) step(1'b1, 4'd0, 16'(k), 1'b0, 4'd0, 1'b0);
    chk("ovf_pvalid", p_valid, 1);
    chk("ovf_pdata", p_data, 0);
    chk("ovf_pprio", p_prio, 15);
`ifdef RL_QM_DROP_CNT_EN
    chk("ovf_drop_cnt", drop_cnt, 2);
`endif
    idle(1'b1);
    chk("ovf_accept", p_valid, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 1'b0);
      chk($sformatf("ovf_qvalid_%0d", k), q_valid, 1);
      chk($sformatf("ovf_qdesc_%0d", k), q_desc, k);
      chk($sformatf("ovf_empty_%0d", k), p_empty, (k == 16) ? 1 : 0);
      idle(1'b0);
      chk($sformatf("ovf_repush_%0d", k), p_valid, (k < 16) ? 1 : 0);
      if (k < 16) begin
        chk($sformatf("ovf_repush_data_%0d", k), p_data, 0);
        idle(1'b1);
      end
    end
    idle(1'b0);
    chk("ovf_done_pvalid", p_valid, 0);
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 1'b0);
    chk("ovf_drained_err", q_err, 1);
    chk("ovf_drained_qvalid", q_valid, 0);

    // Reset in the middle of operation discards queued work.
    step(1'b1, 4'd4, 16'h44, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd4, 16'h45, 1'b0, 4'd0, 1'b0);
    chk("mid_pvalid", p_valid, 1);
    chk("mid_pdata", p_data, 4);
    rst = 1'b1;
    idle(1'b0);
    chk("mid_rst_pvalid", p_valid, 0);
    chk("mid_rst_ready", s_ready, 0);
`ifdef RL_QM_DROP_CNT_EN
    chk("mid_rst_drop_cnt", drop_cnt, 0);
`endif
    rst = 1'b0;
    idle(1'b0);
    chk("mid_ready", s_ready, 1);
    idle(1'b0);
    chk("mid_no_push", p_valid, 0);
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 1'b0);
    chk("mid_req_err", q_err, 1);
    chk("mid_req_qvalid", q_valid, 0);
    idle(1'b0);
    chk("mid_err_pulse", q_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
